// File: rtl/gpio_port.sv
// GPIO port: OUT/DIR/SET/CLR output registers, synchronised IN, optional edge interrupts.
// Define GPIO_PORT_IRQ_EN to build RISE_EN/FALL_EN/STATUS edge detection and irq.
module gpio_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;
    localparam logic [2:0] ADDR_SET     = 3'd6;
    localparam logic [2:0] ADDR_CLR     = 3'd7;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] read_mux;

    assign in_val  = sync_q[SYNC_STAGES-1];
    assign pad_out = out_q;
    assign pad_oe  = dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (we) begin
            case (addr)
                ADDR_OUT: out_q <= wdata;
                ADDR_DIR: dir_q <= wdata;
                ADDR_SET: out_q <= out_q | wdata;
                ADDR_CLR: out_q <= out_q & ~wdata;
                default:  ;
            endcase
        end
    end

`ifdef GPIO_PORT_IRQ_EN
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] delay_q;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c_mask;

    // Delay flop starts at 0 like the sync chain, so only a genuine 1 after reset flags a rise.
    assign edge_set = (in_val & ~delay_q & rise_en_q) | (~in_val & delay_q & fall_en_q);
    assign w1c_mask = (we && addr == ADDR_STATUS) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            delay_q   <= '0;
        end else begin
            delay_q <= in_val;
            if (we && addr == ADDR_RISE_EN) rise_en_q <= wdata;
            if (we && addr == ADDR_FALL_EN) fall_en_q <= wdata;
            // A coincident edge wins over write-one-to-clear.
            status_q <= (status_q & ~w1c_mask) | edge_set;
        end
    end

    assign irq = |status_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        read_mux = '0;
        case (addr)
            ADDR_OUT:     read_mux = out_q;
            ADDR_DIR:     read_mux = dir_q;
            ADDR_IN:      read_mux = in_val;
`ifdef GPIO_PORT_IRQ_EN
            ADDR_RISE_EN: read_mux = rise_en_q;
            ADDR_FALL_EN: read_mux = fall_en_q;
            ADDR_STATUS:  read_mux = status_q;
`endif
            default:      read_mux = '0;
        endcase
    end

    // Read data is sampled pre-write, so a same-cycle write is not visible to the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            rdata  <= re ? read_mux : '0;
        end
    end

endmodule
